timer_apb_regs: RTL and testbench
=================================

Name: timer_apb_regs

Overview:
- APB3 responder and register file that drives the 8-bit up/down timer core and consumes its over/under outputs.
- Converts bus writes into timer controls: tmr_en, tmr_updown, a one-cycle tmr_init_cnt pulse and tmr_data_in.
- Folds tmr_over/tmr_under into sticky write-1-to-clear status flags with a maskable interrupt.
- Sits between the APB interconnect and the timer core.

Parameters:
- WAIT_STATES, 0, number of extra access-phase cycles with pready low; legal range 0..3.
- ADDR_W, 8, paddr width; only paddr[1:0] is decoded, upper bits must be 0 for a hit.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  8  write data.
- prdata  out  8  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error (see Optional Feature).
- tmr_en  out  1  to timer en.
- tmr_updown  out  1  to timer updown; 1 = count up.
- tmr_init_cnt  out  1  to timer init_cnt; one-cycle pulse.
- tmr_data_in  out  8  to timer data_in.
- tmr_over  in  1  from timer over.
- tmr_under  in  1  from timer under.
- irq  out  1  interrupt, level.

Behaviour:
- Register map:
  - 0x0 TDR, RW, reset 0x00: reload value; drives tmr_data_in continuously.
  - 0x1 TCR, RW, reset 0x00:
    - bit0 EN drives tmr_en.
    - bit1 UP drives tmr_updown.
    - bit2 OIE: overflow interrupt enable.
    - bit3 UIE: underflow interrupt enable.
    - bit7 LOAD: write-only strobe, always reads 0.
    - bits6:4 are reserved: read 0, writes ignored.
  - 0x2 TSR, W1C, reset 0x00:
    - bit0 OVF.
    - bit1 UNF.
    - other bits read 0.
  - 0x3 reserved: reads 0x00, writes ignored.
- APB FSM has three states, IDLE, SETUP and ACCESS:
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS on the next cycle. The wait counter loads WAIT_STATES.
  - In ACCESS, pready=0 while the counter is nonzero, and the counter decrements each cycle.
  - When the counter is 0, pready=1 and the transfer completes that cycle.
  - After completion: go to SETUP if psel=1 and penable=0, otherwise go to IDLE.
  - pready=1 in IDLE and SETUP. With WAIT_STATES=0 the access phase lasts exactly 1 cycle.
  - psel dropping mid-access (protocol violation): return to IDLE with no register update.
- Write commit:
  - Registers update on the clock edge ending the completing cycle (pready=1, psel=1, penable=1, pwrite=1).
  - The new value is visible on outputs the next cycle.
- Read data:
  - prdata is combinational from paddr during ACCESS with pready=1.
  - prdata is 0x00 at all other times.
- LOAD:
  - A TCR write with bit7=1 asserts tmr_init_cnt for exactly one cycle, the cycle after commit.
  - tmr_data_in at that moment is the current TDR.
  - The other TCR bits from the same write take effect in that same cycle.
  - Back-to-back LOAD writes give one pulse per write.
- Event qualification:
  - en_d1 and init_d1 are registered copies of tmr_en and tmr_init_cnt.
  - ovf_evt = tmr_over & en_d1 & ~init_d1; unf_evt is the same using tmr_under.
  - This counts consecutive reload-at-0xFF overflows, and does not re-flag a held over while the timer is disabled.
- Sticky flags:
  - OVF is set on ovf_evt; UNF is set on unf_evt.
  - A W1C of a bit clears that bit.
  - If an event and a W1C hit the same bit in the same cycle, the set wins.
  - Writing 0 to a bit has no effect.
- irq = (OVF & OIE) | (UNF & UIE), combinational from registers. Clearing the enable masks irq without clearing the flag.
- Reset, when rst=1 at a clock edge:
  - All registers are 0x00, the FSM is in IDLE and the wait counter is 0.
  - Outputs: tmr_init_cnt=0, tmr_en=0, tmr_updown=0, tmr_data_in=0, irq=0, pready=1, pslverr=0, prdata=0.
  - Reset mid-transfer aborts it with no write commit.

Optional Feature:
- Macro TIMER_APB_SLVERR_EN.
- Defined: a completing access to address 0x3, or with nonzero upper paddr bits, drives pslverr=1 in the pready=1 cycle. The write is ignored and prdata is 0x00.
- Undefined: pslverr is tied 0, and such accesses are silently ignored or read 0x00.

Test Plan:
- Reset then read all addresses -> 0x00 each; pready=1 on the first access cycle with WAIT_STATES=0; irq=0.
- Write TDR=0xFD, write TCR=0x83 -> tmr_init_cnt high for 1 cycle with tmr_data_in=0xFD; tmr_en=1 and tmr_updown=1 from that cycle; TCR reads 0x03.
- Timer model counting up from 0xFD with TCR.OIE=1 -> OVF=1 and irq=1 after overflow; write TSR=0x01 -> OVF=0, irq=0; TDR=0xFF with continuous overflow -> OVF re-sets each cycle.
- W1C to TSR bit1 in the same cycle as unf_evt -> UNF remains 1.
- WAIT_STATES=2 write -> pready low for 2 access cycles, commit only on the third; psel dropped in wait -> register unchanged.
- With TIMER_APB_SLVERR_EN, write 0x55 to 0x3 -> pslverr=1, no state change. Without it -> pslverr=0.

Source files
------------

// File: rtl/timer_apb_regs.sv
// timer_apb_regs: APB3 register file driving an 8-bit up/down timer core; optional TIMER_APB_SLVERR_EN flags bad-address accesses with pslverr
module timer_apb_regs #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              tmr_en,
  output logic              tmr_updown,
  output logic              tmr_init_cnt,
  output logic [7:0]        tmr_data_in,
  input  logic              tmr_over,
  input  logic              tmr_under,
  output logic              irq
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] tdr, tcr;
  logic ovf, unf, init_q, en_d1, init_d1;
  logic hit, done, wr, wr_tsr, ovf_evt, unf_evt, rd_ok;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state = state_q == ACCESS ? ACCESS : psel && !penable ? SETUP : IDLE;
    state_d = state == SETUP ? ACCESS : state == ACCESS && psel && cnt_q != 2'd0 ? ACCESS : IDLE;
    cnt_d = state == SETUP ? 2'(WAIT_STATES) : state == ACCESS && psel && cnt_q != 2'd0 ? cnt_q - 2'd1 : 2'd0;
  end
  always_comb begin
    rd_ok = state == ACCESS && cnt_q == 2'd0;
    pready = state != ACCESS || cnt_q == 2'd0;
    done = rd_ok && psel && penable;
    hit = paddr[ADDR_W-1:2] == '0;
    wr = done && pwrite && hit;
    wr_tsr = wr && paddr[1:0] == 2'd2;
    ovf_evt = tmr_over && en_d1 && !init_d1;
    unf_evt = tmr_under && en_d1 && !init_d1;
    prdata = !rd_ok || !hit ? 8'h00 :
             paddr[1:0] == 2'd0 ? tdr :
             paddr[1:0] == 2'd1 ? tcr :
             paddr[1:0] == 2'd2 ? {6'd0, unf, ovf} : 8'h00;
`ifdef TIMER_APB_SLVERR_EN
    pslverr = done && (!hit || paddr[1:0] == 2'd3);
`else
    pslverr = 1'b0;
`endif
    tmr_en = tcr[0];
    tmr_updown = tcr[1];
    tmr_init_cnt = init_q;
    tmr_data_in = tdr;
    irq = (ovf && tcr[2]) || (unf && tcr[3]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tdr <= 8'h00;
      tcr <= 8'h00;
      ovf <= 1'b0;
      unf <= 1'b0;
      init_q <= 1'b0;
      en_d1 <= 1'b0;
      init_d1 <= 1'b0;
    end else begin
      if (wr && paddr[1:0] == 2'd0) tdr <= pwdata;
      if (wr && paddr[1:0] == 2'd1) tcr <= pwdata & 8'h0F;
      init_q <= wr && paddr[1:0] == 2'd1 && pwdata[7];
      en_d1 <= tcr[0];
      init_d1 <= init_q;
      ovf <= ovf_evt || (ovf && !(wr_tsr && pwdata[0]));
      unf <= unf_evt || (unf && !(wr_tsr && pwdata[1]));
    end
  end
endmodule

// File: tb/tb_timer_apb_regs.sv
// tb_timer_apb_regs: directed and randomized checks of timer_apb_regs against a flag/register reference model
module tb_timer_apb_regs;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic psel[2], penable[2], pwrite[2], pready[2], pslverr[2], tmr_en[2], tmr_updown[2], tmr_init_cnt[2], irq[2];
  logic [7:0] paddr[2], pwdata[2], prdata[2], tmr_data_in[2];
  logic over0, under0;
  logic use_tmr = 1'b0, drv_over = 1'b0, drv_under = 1'b0;
  logic [7:0] tcnt = 8'h00;
  int checks = 0, errors = 0;
`ifdef TIMER_APB_SLVERR_EN
  localparam logic SLV = 1'b1;
`else
  localparam logic SLV = 1'b0;
`endif
  timer_apb_regs #(.WAIT_STATES(0), .ADDR_W(8)) u0 (
    .clk(clk), .rst(rst), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
    .pslverr(pslverr[0]), .tmr_en(tmr_en[0]), .tmr_updown(tmr_updown[0]),
    .tmr_init_cnt(tmr_init_cnt[0]), .tmr_data_in(tmr_data_in[0]),
    .tmr_over(over0), .tmr_under(under0), .irq(irq[0]));
  timer_apb_regs #(.WAIT_STATES(2), .ADDR_W(8)) u1 (
    .clk(clk), .rst(rst), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
    .pslverr(pslverr[1]), .tmr_en(tmr_en[1]), .tmr_updown(tmr_updown[1]),
    .tmr_init_cnt(tmr_init_cnt[1]), .tmr_data_in(tmr_data_in[1]),
    .tmr_over(1'b0), .tmr_under(1'b0), .irq(irq[1]));
  wire t_over = tmr_en[0] && tmr_updown[0] && tcnt == 8'hFF;
  wire t_under = tmr_en[0] && !tmr_updown[0] && tcnt == 8'h00;
  assign over0 = use_tmr ? t_over : drv_over;
  assign under0 = use_tmr ? t_under : drv_under;
  always @(posedge clk)
    tcnt <= tmr_init_cnt[0] ? tmr_data_in[0] : !tmr_en[0] ? tcnt :
            (t_over || t_under) ? tmr_data_in[0] : tmr_updown[0] ? tcnt + 8'd1 : tcnt - 8'd1;
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic chkb(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(int i, logic w, logic [7:0] a, logic [7:0] d, output logic [7:0] r, output logic e, output int waits);
    psel[i] = 1'b1; penable[i] = 1'b0; pwrite[i] = w; paddr[i] = a; pwdata[i] = d;
    tick;
    penable[i] = 1'b1;
    waits = 0;
    #1;
    while (!pready[i] && waits < 8) begin
      tick;
      waits++;
      #1;
    end
    chkb("pready_bound", pready[i], 1'b1);
    r = prdata[i];
    e = pslverr[i];
    tick;
    psel[i] = 1'b0; penable[i] = 1'b0;
  endtask
  task automatic apb_wr(int i, logic [7:0] a, logic [7:0] d);
    logic [7:0] r;
    logic e;
    int w;
    xfer(i, 1'b1, a, d, r, e, w);
  endtask
  task automatic apb_rd(int i, logic [7:0] a, output logic [7:0] r);
    logic e;
    int w;
    xfer(i, 1'b0, a, 8'h00, r, e, w);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] r, d, m_tdr;
    logic [3:0] m_tcr;
    logic e, m_ovf, m_unf;
    int w;
    for (int i = 0; i < 2; i++) begin
      psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0; paddr[i] = 8'h00; pwdata[i] = 8'h00;
    end
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chkb("rst_pready", pready[0], 1'b1);
    chkb("rst_pslverr", pslverr[0], 1'b0);
    chk("rst_prdata", prdata[0], 8'h00);
    chkb("rst_en", tmr_en[0], 1'b0);
    chkb("rst_updown", tmr_updown[0], 1'b0);
    chkb("rst_init", tmr_init_cnt[0], 1'b0);
    chk("rst_data_in", tmr_data_in[0], 8'h00);
    chkb("rst_irq", irq[0], 1'b0);
    for (int a = 0; a < 4; a++) begin
      xfer(0, 1'b0, 8'(a), 8'h00, r, e, w);
      chk("rst_read", r, 8'h00);
      chk("rst_read_waits", 8'(w), 8'd0);
    end
    use_tmr = 1'b1;
    apb_wr(0, 8'h00, 8'hFD);
    chk("tdr_drive", tmr_data_in[0], 8'hFD);
    apb_wr(0, 8'h01, 8'h83);
    chkb("load_pulse", tmr_init_cnt[0], 1'b1);
    chk("load_data", tmr_data_in[0], 8'hFD);
    chkb("load_en", tmr_en[0], 1'b1);
    chkb("load_up", tmr_updown[0], 1'b1);
    tick;
    chkb("load_pulse_end", tmr_init_cnt[0], 1'b0);
    apb_rd(0, 8'h01, r);
    chk("tcr_read", r, 8'h03);
    apb_wr(0, 8'h01, 8'h07);
    chkb("ovf_irq", irq[0], 1'b1);
    apb_rd(0, 8'h02, r);
    chk("ovf_flag", r, 8'h01);
    apb_wr(0, 8'h01, 8'h06);
    apb_wr(0, 8'h02, 8'h01);
    chkb("w1c_irq", irq[0], 1'b0);
    apb_rd(0, 8'h02, r);
    chk("w1c_flag", r, 8'h00);
    apb_wr(0, 8'h00, 8'hFF);
    apb_wr(0, 8'h01, 8'h87);
    tick;
    tick;
    chkb("init_mask", irq[0], 1'b0);
    tick;
    chkb("reload_ovf", irq[0], 1'b1);
    apb_wr(0, 8'h02, 8'h01);
    apb_rd(0, 8'h02, r);
    chk("ovf_reset_each", r, 8'h01);
    apb_wr(0, 8'h01, 8'h03);
    chkb("oie_mask", irq[0], 1'b0);
    apb_rd(0, 8'h02, r);
    chk("mask_keeps_flag", r, 8'h01);
    apb_wr(0, 8'h01, 8'h00);
    tick;
    tick;
    apb_wr(0, 8'h02, 8'h01);
    apb_rd(0, 8'h02, r);
    chk("disabled_clear", r, 8'h00);
    use_tmr = 1'b0;
    apb_wr(0, 8'h01, 8'h09);
    tick;
    tick;
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h02; pwdata[0] = 8'h02;
    tick;
    penable[0] = 1'b1;
    drv_under = 1'b1;
    tick;
    psel[0] = 1'b0; penable[0] = 1'b0; drv_under = 1'b0;
    apb_rd(0, 8'h02, r);
    chk("set_wins", r, 8'h02);
    chkb("unf_irq", irq[0], 1'b1);
    apb_wr(0, 8'h02, 8'h02);
    apb_rd(0, 8'h02, r);
    chk("unf_clear", r, 8'h00);
    xfer(1, 1'b1, 8'h00, 8'hA5, r, e, w);
    chk("ws_waits", 8'(w), 8'd2);
    chk("ws_write", tmr_data_in[1], 8'hA5);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h00; pwdata[1] = 8'h3C;
    tick;
    penable[1] = 1'b1;
    #1;
    chkb("ws_wait1", pready[1], 1'b0);
    tick;
    chkb("ws_wait2", pready[1], 1'b0);
    chk("ws_nocommit", tmr_data_in[1], 8'hA5);
    tick;
    chkb("ws_ready", pready[1], 1'b1);
    chk("ws_nocommit_ready", tmr_data_in[1], 8'hA5);
    tick;
    psel[1] = 1'b0; penable[1] = 1'b0;
    chk("ws_commit", tmr_data_in[1], 8'h3C);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h00; pwdata[1] = 8'h77;
    tick;
    penable[1] = 1'b1;
    tick;
    psel[1] = 1'b0; penable[1] = 1'b0;
    tick;
    tick;
    chk("ws_abort", tmr_data_in[1], 8'h3C);
    apb_rd(1, 8'h00, r);
    chk("ws_abort_read", r, 8'h3C);
    xfer(0, 1'b1, 8'h03, 8'h55, r, e, w);
    chkb("slv_wr3", e, SLV);
    xfer(0, 1'b1, 8'h40, 8'h55, r, e, w);
    chkb("slv_wr_hi", e, SLV);
    apb_rd(0, 8'h00, r);
    chk("slv_tdr_kept", r, 8'hFF);
    xfer(0, 1'b0, 8'h03, 8'h00, r, e, w);
    chk("rd3_data", r, 8'h00);
    chkb("slv_rd3", e, SLV);
    xfer(0, 1'b0, 8'h41, 8'h00, r, e, w);
    chk("rd_hi_data", r, 8'h00);
    chkb("slv_rd_hi", e, SLV);
    xfer(0, 1'b0, 8'h01, 8'h00, r, e, w);
    chkb("slv_ok", e, 1'b0);
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h00; pwdata[1] = 8'h11;
    tick;
    penable[1] = 1'b1;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    tick;
    chkb("rst_mid_pready", pready[1], 1'b1);
    chk("rst_mid_tdr", tmr_data_in[1], 8'h00);
    chkb("rst_irq2", irq[0], 1'b0);
    m_tdr = 8'h00; m_tcr = 4'h0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0: begin
          drv_over = 1'($urandom);
          drv_under = 1'($urandom);
          tick;
          m_ovf = m_ovf | (drv_over & m_tcr[0]);
          m_unf = m_unf | (drv_under & m_tcr[0]);
          drv_over = 1'b0; drv_under = 1'b0;
        end
        1: begin
          d = 8'($urandom);
          apb_wr(0, 8'h01, d);
          chkb("rnd_load", tmr_init_cnt[0], d[7]);
          m_tcr = d[3:0];
          tick;
          tick;
          chkb("rnd_en", tmr_en[0], m_tcr[0]);
          chkb("rnd_up", tmr_updown[0], m_tcr[1]);
        end
        2: begin
          d = 8'($urandom);
          apb_wr(0, 8'h00, d);
          m_tdr = d;
          chk("rnd_tdr", tmr_data_in[0], m_tdr);
        end
        3: begin
          d = 8'($urandom);
          apb_wr(0, 8'h02, d);
          m_ovf = m_ovf & ~d[0];
          m_unf = m_unf & ~d[1];
          tick;
        end
        default: begin
          d = 8'($urandom_range(0, 3));
          apb_rd(0, d, r);
          chk("rnd_read", r, d == 8'd0 ? m_tdr : d == 8'd1 ? {4'h0, m_tcr} : d == 8'd2 ? {6'd0, m_unf, m_ovf} : 8'h00);
        end
      endcase
      chkb("rnd_irq", irq[0], (m_ovf & m_tcr[2]) | (m_unf & m_tcr[3]));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
